// File: rtl/calc_sequencer.sv
// Keypad-to-ALU sequencer: builds two-digit BCD operands from key strobes, runs the
// buffered op1/op2/enable load sequence of the BCD ALU and holds the result for display.
module calc_sequencer (
  input  logic       clk,
  input  logic       nrst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic [8:0] alu_result,
  output logic [8:0] alu_op,
  output logic [2:0] alu_opcode,
  output logic       assign_op1,
  output logic       assign_op2,
  output logic       alu_en,
  output logic [8:0] disp_value,
  output logic       busy,
  output logic       result_valid
);

  typedef enum logic [2:0] {ENTRY1, ENTRY2, C0, C1, C2, C3, SHOW} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB} pend_t;

  state_t     state, state_nxt;
  pend_t      pend, pend_nxt, key_op;
  logic [8:0] op_a, op_a_nxt;
  logic [7:0] entry, entry_nxt;
  logic [1:0] dcnt, dcnt_nxt;
  logic [8:0] result, result_nxt;
  logic [8:0] alu_op_nxt, disp_nxt;
  logic       is_digit, is_oper, is_eq, is_clr, seq_nxt;

  assign is_digit = key_valid && (key_code < 4'd10);
  assign is_oper  = key_valid && ((key_code == 4'hA) || (key_code == 4'hB));
  assign is_eq    = key_valid && (key_code == 4'hC);
  assign is_clr   = key_valid && (key_code == 4'hD);
  assign key_op   = (key_code == 4'hB) ? OP_SUB : OP_ADD;

  always_comb begin
    state_nxt  = state;
    pend_nxt   = pend;
    op_a_nxt   = op_a;
    entry_nxt  = entry;
    dcnt_nxt   = dcnt;
    result_nxt = result;
    if (is_clr) begin
      state_nxt  = ENTRY1;
      pend_nxt   = OP_NONE;
      op_a_nxt   = '0;
      entry_nxt  = '0;
      dcnt_nxt   = '0;
      result_nxt = '0;
    end else begin
      case (state)
        ENTRY1: begin
          if (is_digit && dcnt < 2'd2) begin
            entry_nxt = {entry[3:0], key_code};
            dcnt_nxt  = dcnt + 2'd1;
          end else if (is_oper) begin
            op_a_nxt  = {1'b0, entry};
            pend_nxt  = key_op;
            entry_nxt = '0;
            dcnt_nxt  = '0;
            state_nxt = ENTRY2;
          end
        end
        ENTRY2: begin
          if (is_digit && dcnt < 2'd2) begin
            entry_nxt = {entry[3:0], key_code};
            dcnt_nxt  = dcnt + 2'd1;
          end else if (is_oper && dcnt == 2'd0) begin
            pend_nxt = key_op;
          end else if (is_eq) begin
            state_nxt = C0;
          end
        end
        C0: state_nxt = C1;
        C1: state_nxt = C2;
        C2: state_nxt = C3;
        C3: begin
          result_nxt = alu_result;
          state_nxt  = SHOW;
        end
        SHOW: begin
          if (is_digit) begin
            entry_nxt = {4'h0, key_code};
            dcnt_nxt  = 2'd1;
            state_nxt = ENTRY1;
          end else if (is_oper) begin
            op_a_nxt  = result;
            pend_nxt  = key_op;
            entry_nxt = '0;
            dcnt_nxt  = '0;
            state_nxt = ENTRY2;
          end
        end
        default: state_nxt = ENTRY1;
      endcase
    end
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_comb begin
    seq_nxt    = (state_nxt == C0) || (state_nxt == C1) || (state_nxt == C2) || (state_nxt == C3);
    alu_op_nxt = '0;
    if (state_nxt == C0 || state_nxt == C1) alu_op_nxt = op_a_nxt;
    else if (state_nxt == C2)               alu_op_nxt = {1'b0, entry_nxt};
    disp_nxt = '0;
    if (seq_nxt || state_nxt == SHOW) disp_nxt = result_nxt;
    else if (dcnt_nxt != 2'd0)        disp_nxt = {1'b0, entry_nxt};
    else if (state_nxt == ENTRY2)     disp_nxt = op_a_nxt;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= ENTRY1;
      pend         <= OP_NONE;
      op_a         <= '0;
      entry        <= '0;
      dcnt         <= '0;
      result       <= '0;
      alu_op       <= '0;
      alu_opcode   <= '0;
      assign_op1   <= 1'b0;
      assign_op2   <= 1'b0;
      alu_en       <= 1'b0;
      disp_value   <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      pend         <= pend_nxt;
      op_a         <= op_a_nxt;
      entry        <= entry_nxt;
      dcnt         <= dcnt_nxt;
      result       <= result_nxt;
      alu_op       <= alu_op_nxt;
      alu_opcode   <= (pend_nxt == OP_ADD) ? 3'b001 : (pend_nxt == OP_SUB) ? 3'b010 : 3'b000;
      assign_op1   <= (state_nxt == C0);
      assign_op2   <= (state_nxt == C1);
      alu_en       <= (state_nxt == C3);
      disp_value   <= disp_nxt;
      busy         <= seq_nxt;
      result_valid <= (state == C3) && (state_nxt == SHOW);
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: a stand-in BCD ALU, an integer-level calculator model
// compared every cycle, plus directed key sequences with literal expectations.
module tb_calc_sequencer;
  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [8:0] alu_result;
  logic [8:0] alu_op;
  logic [2:0] alu_opcode;
  logic       assign_op1, assign_op2, alu_en, busy, result_valid;
  logic [8:0] disp_value;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  calc_sequencer dut (
    .clk(clk), .nrst(nrst), .key_valid(key_valid), .key_code(key_code),
    .alu_result(alu_result), .alu_op(alu_op), .alu_opcode(alu_opcode),
    .assign_op1(assign_op1), .assign_op2(assign_op2), .alu_en(alu_en),
    .disp_value(disp_value), .busy(busy), .result_valid(result_valid)
  );

  function automatic int dec(input logic [8:0] v);
    int m;
    m = int'(v[7:4]) * 10 + int'(v[3:0]);
    return v[8] ? -m : m;
  endfunction

  function automatic int wrap(input int r);
    int m;
    m = (r < 0 ? -r : r) % 100;
    return (r < 0) ? -m : m;
  endfunction

  function automatic logic [8:0] enc(input int v);
    int m;
    logic [8:0] r;
    m = (v < 0) ? -v : v;
    r[8]   = (v < 0);
    r[7:4] = 4'(m / 10);
    r[3:0] = 4'(m % 10);
    return r;
  endfunction

  // ALU stand-in: latches alu_op one cycle after each assign pulse, computes combinationally
  logic       a1_d, a2_d;
  logic [8:0] op1, op2;
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      a1_d <= 1'b0; a2_d <= 1'b0; op1 <= '0; op2 <= '0;
    end else begin
      a1_d <= assign_op1;
      a2_d <= assign_op2;
      if (a1_d) op1 <= alu_op;
      if (a2_d) op2 <= alu_op;
    end
  end
  always_comb begin
    case (alu_opcode)
      3'b001:  alu_result = enc(wrap(dec(op1) + dec(op2)));
      3'b010:  alu_result = enc(wrap(dec(op1) - dec(op2)));
      default: alu_result = '0;
    endcase
  end

  // Calculator model: mode 0 first operand, 1 second operand, 2 showing result;
  // phase 1..4 counts the four ALU sequence cycles.
  int m_mode = 0, m_phase = 0, m_a = 0, m_e = 0, m_nd = 0, m_op = 0, m_res = 0;
  bit m_rv = 1'b0;
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_mode = 0; m_phase = 0; m_a = 0; m_e = 0; m_nd = 0; m_op = 0; m_res = 0; m_rv = 1'b0;
    end else begin
      m_rv = 1'b0;
      if (key_valid && key_code == 4'hD) begin
        m_mode = 0; m_phase = 0; m_a = 0; m_e = 0; m_nd = 0; m_op = 0; m_res = 0;
      end else if (m_phase == 4) begin
        m_res   = wrap((m_op == 2) ? m_a - m_e : m_a + m_e);
        m_phase = 0;
        m_mode  = 2;
        m_rv    = 1'b1;
      end else if (m_phase > 0) begin
        m_phase++;
      end else if (key_valid) begin
        if (key_code <= 4'd9) begin
          if (m_mode == 2) begin
            m_e = int'(key_code); m_nd = 1; m_mode = 0;
          end else if (m_nd < 2) begin
            m_e = m_e * 10 + int'(key_code); m_nd++;
          end
        end else if (key_code == 4'hA || key_code == 4'hB) begin
          if (m_mode == 0) begin
            m_a = m_e; m_op = (key_code == 4'hB) ? 2 : 1; m_e = 0; m_nd = 0; m_mode = 1;
          end else if (m_mode == 2) begin
            m_a = m_res; m_op = (key_code == 4'hB) ? 2 : 1; m_e = 0; m_nd = 0; m_mode = 1;
          end else if (m_nd == 0) begin
            m_op = (key_code == 4'hB) ? 2 : 1;
          end
        end else if (key_code == 4'hC && m_mode == 1) begin
          m_phase = 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [8:0] e_op, e_disp;
    logic [4:0] e_ctrl;
    e_op = '0;
    if (m_phase == 1 || m_phase == 2) e_op = enc(m_a);
    else if (m_phase == 3)            e_op = enc(m_e);
    if (m_phase > 0 || m_mode == 2) e_disp = enc(m_res);
    else if (m_nd > 0)              e_disp = enc(m_e);
    else if (m_mode == 1)           e_disp = enc(m_a);
    else                            e_disp = '0;
    e_ctrl = {m_phase > 0, m_phase == 1, m_phase == 2, m_phase == 4, m_rv};
    check("model alu_op", alu_op, e_op);
    check("model alu_opcode", {6'b0, alu_opcode}, (m_op == 2) ? 9'd2 : (m_op == 1) ? 9'd1 : 9'd0);
    check("model disp_value", disp_value, e_disp);
    check("model ctrl", {4'b0, busy, assign_op1, assign_op2, alu_en, result_valid}, {4'b0, e_ctrl});
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  function automatic logic [8:0] ctrl();
    return {4'b0, busy, assign_op1, assign_op2, alu_en, result_valid};
  endfunction

  initial begin
    idle(2);
    nrst = 1'b1;
    idle(1);
    check("reset disp", disp_value, 9'h000);
    check("reset alu_op", alu_op, 9'h000);
    check("reset ctrl", ctrl(), 9'h000);

    press(4'h1); press(4'h2); press(4'hA); press(4'h7); press(4'hC);
    check("add C0 alu_op", alu_op, 9'h012);
    check("add C0 ctrl", ctrl(), 9'b0_0001_1000);
    check("add opcode", {6'b0, alu_opcode}, 9'h001);
    idle(1);
    check("add C1 alu_op", alu_op, 9'h012);
    check("add C1 ctrl", ctrl(), 9'b0_0001_0100);
    idle(1);
    check("add C2 alu_op", alu_op, 9'h007);
    idle(1);
    check("add C3 ctrl", ctrl(), 9'b0_0001_0010);
    idle(1);
    check("add result_valid", ctrl(), 9'b0_0000_0001);
    check("add disp", disp_value, 9'h019);

    press(4'hD);
    press(4'h2); press(4'h5); press(4'hB); press(4'h9); press(4'hC);
    check("sub opcode C0", {6'b0, alu_opcode}, 9'h002);
    idle(4);
    check("sub disp", disp_value, 9'h016);
    press(4'hA); press(4'h3); press(4'hC);
    check("chain C0 alu_op", alu_op, 9'h016);
    idle(4);
    check("chain disp", disp_value, 9'h019);

    press(4'hD);
    press(4'h1); press(4'h2); press(4'h3);
    check("third digit ignored", disp_value, 9'h012);
    press(4'hA); press(4'hB); press(4'h4); press(4'hC);
    check("replaced opcode", {6'b0, alu_opcode}, 9'h002);
    idle(2);
    check("replaced C2 alu_op", alu_op, 9'h004);
    idle(2);
    check("replaced disp", disp_value, 9'h008);

    press(4'hD);
    press(4'h4); press(4'hA); press(4'h5); press(4'hC);
    idle(1);
    press(4'hD);
    check("abort ctrl", ctrl(), 9'h000);
    check("abort disp", disp_value, 9'h000);
    idle(5);
    check("abort quiet", ctrl(), 9'h000);

    press(4'h3); press(4'hA); press(4'h4); press(4'hC);
    press(4'h9);
    idle(3);
    check("busy digit dropped disp", disp_value, 9'h007);
    press(4'hA);
    check("chained opA disp", disp_value, 9'h007);
    press(4'hC);
    idle(5);

    press(4'hD);
    press(4'h1); press(4'hA); press(4'h2); press(4'hC);
    idle(1);
    #2 nrst = 1'b0;
    #1;
    check("async reset ctrl", ctrl(), 9'h000);
    check("async reset alu_op", alu_op, 9'h000);
    check("async reset disp", disp_value, 9'h000);
    @(posedge clk); #1;
    nrst = 1'b1;
    idle(1);

    repeat (3000) begin
      key_valid = 1'($urandom_range(0, 1));
      key_code  = 4'($urandom_range(0, 15));
      if (key_code == 4'hD && $urandom_range(0, 3) != 0) key_code = 4'hC;
      @(posedge clk); #1;
    end
    key_valid = 1'b0;
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Keypad-to-ALU sequencer for the calculator datapath. Accepts decoded key strobes, builds two-digit BCD operands, and drives the buffered operand/opcode load protocol of the BCD add/subtract ALU. It captures the 9-bit sign-magnitude result and presents it for display. It supports chaining a shown result into the next operation.

## Interface
- No parameters.
- clk  input  1  system clock
- nrst  input  1  reset, asynchronous, active-low
- key_valid  input  1  one-cycle strobe, key_code valid
- key_code  input  4  0–9 digit, 4'hA add, 4'hB subtract, 4'hC equals, 4'hD clear, 4'hE/4'hF ignored
- alu_result  input  9  combinational ALU result (bit 8 sign, [7:4] tens BCD, [3:0] units BCD)
- alu_op  output  9  operand bus to ALU
- alu_opcode  output  3  3'b001 add, 3'b010 subtract, 3'b000 idle
- assign_op1  output  1  op1 load request (ALU latches alu_op one cycle later)
- assign_op2  output  1  op2 load request (ALU latches alu_op one cycle later)
- alu_en  output  1  ALU compute enable
- disp_value  output  9  value for display driver
- busy  output  1  ALU sequence in progress
- result_valid  output  1  one-cycle pulse when result captured

## Operation
- Registers: opA[8:0], entry[7:0] BCD, dcnt[1:0], pend_op[1:0] (none/add/sub), result[8:0].
- States: ENTRY1, ENTRY2, C0, C1, C2, C3, SHOW.
- Digit entry (ENTRY1/ENTRY2): if dcnt<2, entry <= {entry[3:0], digit}, dcnt++. Third and later digits are ignored. Entered operands are positive (bit 8 = 0).
- ENTRY1:
  - operator key → opA <= {0,entry}, pend_op set, entry/dcnt cleared, go ENTRY2.
  - '=' is ignored.
- ENTRY2:
  - operator with dcnt==0 → replaces pend_op.
  - operator with dcnt>0 → ignored.
  - '=' → go C0; opB = {0,entry}, 0 if no digits.
- ALU load protocol, one cycle per state:
  - C0: alu_op=opA, assign_op1=1.
  - C1: alu_op=opA, assign_op2=1 (ALU latches op1 at end of C1).
  - C2: alu_op=opB (ALU latches op2 at end of C2).
  - C3: alu_en=1; result <= alu_result at end of C3; result_valid pulses in the following cycle; go SHOW.
- alu_opcode = encoding of pend_op whenever pend_op≠none, else 3'b000. It is stable from entry to ENTRY2 through C3, so the ALU's opcode buffer is settled.
- SHOW:
  - digit → entry cleared, then the digit is entered, go ENTRY1.
  - operator → opA <= result (sign kept), pend_op set, go ENTRY2.
  - '=' is ignored.
- Clear (any state, including C0–C3): opA, entry, dcnt, pend_op, result ← 0, go ENTRY1. All ALU controls are 0 from the next cycle; an aborted sequence does not update result.
- Keys other than clear during C0–C3 are dropped.
- disp_value:
  - {0,entry} in ENTRY1/ENTRY2 when dcnt>0.
  - opA in ENTRY2 when dcnt==0.
  - result in C0–C3 and SHOW.
- alu_op = 0 when not in C0–C2.

## Timing
- Reset values: all outputs 0, state ENTRY1, all registers 0.
- Key sampled on the clk edge where key_valid=1. State and registers update on that edge.
- '=' accepted at edge t → C0 is cycle t+1, C3 is cycle t+4 → result and disp_value updated and result_valid=1 in cycle t+5.
- busy=1 exactly in C0–C3 (4 cycles).
- assign_op1 and assign_op2 are single-cycle pulses, never high together.
- alu_en is high only in C3.
- Back-to-back key strobes on consecutive cycles are each processed unless dropped by the rules above.
- Asynchronous reset mid-sequence forces the reset values immediately.

## Test plan
- Reset, no keys → all outputs 0, disp_value 9'h000.
- Keys 1,2,+,7,= → alu_op 9'h012 in C0 and C1, 9'h007 in C2, assign_op1 in C0, assign_op2 in C1, alu_opcode 3'b001, alu_en in C3. With the ALU attached: result_valid at t+5, disp_value 9'h019.
- Keys 2,5,−,9,= → alu_opcode 3'b010 through C3, disp_value 9'h016 after result_valid. Then keys +,3,= → alu_op 9'h016 in C0, disp_value 9'h019.
- Keys 1,2,3 → disp_value 9'h012 (third digit ignored). Then +,−,4,= → alu_opcode 3'b010 (pend_op replaced), alu_op 9'h004 in C2.
- Keys 4,+,5,= then clear in C1 → busy=0 next cycle, assign/alu_en stay 0, no result_valid, disp_value 9'h000, state ENTRY1.
- Digit key asserted during busy → ignored; entry unchanged after SHOW.
